// File: rtl/dds_pkg.sv
// Shared definitions for the dds_gen numerically controlled oscillator.
//   - waveform mode encodings (mode port)
//   - frequency-tuning-word handshake state encoding
//   - dither LFSR seed/taps and its step function (used only when DDS_DITHER_EN is defined)
package dds_pkg;

    localparam logic [1:0] MODE_SINE = 2'd0;
    localparam logic [1:0] MODE_SAW  = 2'd1;
    localparam logic [1:0] MODE_TRI  = 2'd2;
    localparam logic [1:0] MODE_SQR  = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } ftw_state_e;

    // x^16 + x^14 + x^13 + x^11 + 1 as a right-shifting Fibonacci register:
    // feedback is the XOR of bits 0, 2, 3 and 5, shifted in at bit 15.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/dds_qrom.sv
// Registered quarter-wave sine ROM.
//   clk  : rising-edge clock
//   addr : quadrant-folded index, ADDR_WIDTH-2 bits
//   q    : round(A*sin(2*pi*(addr+0.5)/2^ADDR_WIDTH)), A = 2^(OUT_WIDTH-1)-1, unsigned,
//          OUT_WIDTH-1 bits, one cycle after addr
// Contents are computed at elaboration by a fixed-point Taylor series.
module dds_qrom
    import dds_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned OUT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-3:0] addr,
    output logic [OUT_WIDTH-2:0]  q
);

    localparam int unsigned N    = 1 << (ADDR_WIDTH - 2);
    localparam int unsigned AMP  = (1 << (OUT_WIDTH - 1)) - 1;
    localparam int unsigned FX   = 28;
    localparam longint      PI_FX = 64'sd843314857; // pi * 2^28

    function automatic logic [OUT_WIDTH-2:0] sine_word(input int unsigned k);
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint r;
        // x = pi*(2k+1)/2^ADDR_WIDTH, always inside the first quadrant
        x    = (PI_FX * longint'(2 * k + 1)) >>> ADDR_WIDTH;
        x2   = (x * x) >>> FX;
        term = x;
        sum  = x;
        for (int n = 1; n <= 7; n++) begin
            term = -(((term * x2) >>> FX) / longint'(4 * n * n + 2 * n));
            sum  = sum + term;
        end
        r = (sum * longint'(AMP) + (longint'(1) <<< (FX - 1))) >>> FX;
        return r[OUT_WIDTH-2:0];
    endfunction

    logic [OUT_WIDTH-2:0] rom [N];

    for (genvar k = 0; k < N; k++) begin : g_rom
        assign rom[k] = sine_word(k);
    end

    always_ff @(posedge clk) begin
        q <= rom[addr];
    end

endmodule

// File: rtl/dds_gen.sv
// Parametrised DDS function generator / NCO.
//   clk, reset(active-low, async) ; en advances the phase accumulator
//   ftw_in/ftw_valid/ftw_ready/ftw_sync : tuning-word load handshake; ftw_sync=1 defers the
//                                         new word to the next accumulator wrap
//   phase_off : offset added to the lookup phase ; phase_clr : synchronous accumulator clear
//   mode      : 0 sine, 1 sawtooth, 2 triangle, 3 square
//   wave/wave_valid : signed sample, 3 cycles after the accumulator register
//   acc_msb   : top ADDR_WIDTH accumulator bits, no added latency
// Optional: define DDS_DITHER_EN to add LFSR phase dither ahead of truncation.
module dds_gen
    import dds_pkg::*;
#(
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned OUT_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic [ACC_WIDTH-1:0]        ftw_in,
    input  logic                        ftw_valid,
    output logic                        ftw_ready,
    input  logic                        ftw_sync,
    input  logic [ADDR_WIDTH-1:0]       phase_off,
    input  logic                        phase_clr,
    input  logic [1:0]                  mode,
    output logic signed [OUT_WIDTH-1:0] wave,
    output logic                        wave_valid,
    output logic [ADDR_WIDTH-1:0]       acc_msb
);

    localparam logic signed [OUT_WIDTH-1:0] AMP = {1'b0, {(OUT_WIDTH - 1){1'b1}}};

    ftw_state_e           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] ftw_q, ftw_d;
    logic [ACC_WIDTH-1:0] shadow_q, shadow_d;
    logic [ACC_WIDTH-1:0] acc_sum;
    logic                 acc_carry;

    assign {acc_carry, acc_sum} = {1'b0, acc_q} + {1'b0, ftw_q};
    assign ftw_ready = (state_q == ST_IDLE);
    assign acc_msb   = acc_q[ACC_WIDTH-1 -: ADDR_WIDTH];

    always_comb begin
        acc_d    = acc_q;
        ftw_d    = ftw_q;
        shadow_d = shadow_q;
        state_d  = state_q;
        if (en) begin
            acc_d = acc_sum;
        end
        if (phase_clr) begin
            // Clear wins over any word offered this cycle; a pending word lands now.
            acc_d = '0;
            if (state_q == ST_PEND) begin
                ftw_d   = shadow_q;
                state_d = ST_IDLE;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (ftw_valid) begin
                        if (ftw_sync) begin
                            shadow_d = ftw_in;
                            state_d  = ST_PEND;
                        end else begin
                            ftw_d = ftw_in;
                        end
                    end
                end
                ST_PEND: begin
                    // The wrapping add itself still uses the old word.
                    if (en && acc_carry) begin
                        ftw_d   = shadow_q;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Lookup phase before truncation, optionally dithered.
    logic [ADDR_WIDTH-1:0] acc_top;

`ifdef DDS_DITHER_EN
    localparam int unsigned DITH_W =
        (ACC_WIDTH - ADDR_WIDTH > 16) ? 16 : ACC_WIDTH - ADDR_WIDTH;
    localparam logic [15:0] DITH_MASK = 16'((32'd1 << DITH_W) - 32'd1);

    logic [15:0]          lfsr_q, lfsr_d;
    logic [ACC_WIDTH-1:0] acc_dith;

    assign lfsr_d   = en ? lfsr_next(lfsr_q) : lfsr_q;
    assign acc_dith = acc_q + ACC_WIDTH'(lfsr_q & DITH_MASK);
    assign acc_top  = acc_dith[ACC_WIDTH-1 -: ADDR_WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign acc_top = acc_q[ACC_WIDTH-1 -: ADDR_WIDTH];
`endif

    // S1: phase + offset, mode and valid
    logic [ADDR_WIDTH-1:0] p1_q, p1_d;
    logic [1:0]            mode1_q;
    logic                  v1_q;
    // S2: phase, mode, valid alongside the registered ROM word
    logic [ADDR_WIDTH-1:0] p2_q;
    logic [1:0]            mode2_q;
    logic                  v2_q;
    logic [ADDR_WIDTH-3:0] rom_addr;
    logic [OUT_WIDTH-2:0]  rom_q;
    // S3: output sample
    logic signed [OUT_WIDTH-1:0] wave_q, wave_d;
    logic                        wave_valid_q;

    assign p1_d = acc_top + phase_off;

    // Odd quadrants read the quarter wave backwards: N-1-i is the bitwise inverse of i.
    assign rom_addr = p1_q[ADDR_WIDTH-2] ? ~p1_q[ADDR_WIDTH-3:0] : p1_q[ADDR_WIDTH-3:0];

    dds_qrom #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_qrom (
        .clk (clk),
        .addr(rom_addr),
        .q   (rom_q)
    );

    logic                        p2_msb;
    logic [ADDR_WIDTH-2:0]       tri_u;
    logic [OUT_WIDTH-1:0]        saw_raw;
    logic [OUT_WIDTH-1:0]        tri_raw;
    logic signed [OUT_WIDTH-1:0] sine_pos;

    assign p2_msb   = p2_q[ADDR_WIDTH-1];
    assign tri_u    = p2_q[ADDR_WIDTH-2:0] ^ {(ADDR_WIDTH - 1){p2_msb}};
    assign sine_pos = $signed({1'b0, rom_q});

    if (ADDR_WIDTH >= OUT_WIDTH) begin : g_saw_trunc
        assign saw_raw = p2_q[ADDR_WIDTH-1 -: OUT_WIDTH];
    end else begin : g_saw_pad
        assign saw_raw = {p2_q, {(OUT_WIDTH - ADDR_WIDTH){1'b0}}};
    end

    // Padding bits are inverted along with u so the falling half peaks at +max.
    if (ADDR_WIDTH > OUT_WIDTH) begin : g_tri_trunc
        assign tri_raw = tri_u[ADDR_WIDTH-2 -: OUT_WIDTH];
    end else begin : g_tri_pad
        assign tri_raw = {tri_u, {(OUT_WIDTH - ADDR_WIDTH + 1){p2_msb}}};
    end

    always_comb begin
        wave_d = '0;
        unique case (mode2_q)
            MODE_SINE: wave_d = p2_msb ? -sine_pos : sine_pos;
            MODE_SAW:  wave_d = $signed({~saw_raw[OUT_WIDTH-1], saw_raw[OUT_WIDTH-2:0]});
            MODE_TRI:  wave_d = $signed({~tri_raw[OUT_WIDTH-1], tri_raw[OUT_WIDTH-2:0]});
            MODE_SQR:  wave_d = p2_msb ? -AMP : AMP;
            default:   wave_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            ftw_q        <= '0;
            shadow_q     <= '0;
            p1_q         <= '0;
            mode1_q      <= MODE_SINE;
            v1_q         <= 1'b0;
            p2_q         <= '0;
            mode2_q      <= MODE_SINE;
            v2_q         <= 1'b0;
            wave_q       <= '0;
            wave_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            ftw_q        <= ftw_d;
            shadow_q     <= shadow_d;
            p1_q         <= p1_d;
            mode1_q      <= mode;
            v1_q         <= en;
            p2_q         <= p1_q;
            mode2_q      <= mode1_q;
            v2_q         <= v1_q;
            wave_q       <= wave_d;
            wave_valid_q <= v2_q;
        end
    end

    assign wave       = wave_q;
    assign wave_valid = wave_valid_q;

endmodule

// File: tb/tb_dds_gen.sv
module tb_dds_gen;

    localparam int AW = 8;
    localparam int OW = 8;
    localparam int CW = 32;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 en;
    logic [CW-1:0]        ftw_in;
    logic                 ftw_valid;
    logic                 ftw_ready;
    logic                 ftw_sync;
    logic [AW-1:0]        phase_off;
    logic                 phase_clr;
    logic [1:0]           mode;
    logic signed [OW-1:0] wave;
    logic                 wave_valid;
    logic [AW-1:0]        acc_msb;

    dds_gen #(
        .ACC_WIDTH (CW),
        .ADDR_WIDTH(AW),
        .OUT_WIDTH (OW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .ftw_in    (ftw_in),
        .ftw_valid (ftw_valid),
        .ftw_ready (ftw_ready),
        .ftw_sync  (ftw_sync),
        .phase_off (phase_off),
        .phase_clr (phase_clr),
        .mode      (mode),
        .wave      (wave),
        .wave_valid(wave_valid),
        .acc_msb   (acc_msb)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Expected accumulator, from the bench's own view of the stimulus.
    logic [CW-1:0] m_acc;
    logic [CW-1:0] m_ftw;
    logic          m_carry;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        m_carry = 1'b0;
        if (phase_clr) m_acc = '0;
        else if (en) {m_carry, m_acc} = {1'b0, m_acc} + {1'b0, m_ftw};
    endtask

    // Mode vectors at fixed phase (acc held at 0, phase_off selects p).
    int tv_mode [16] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3};
    int tv_p    [16] = '{0, 64, 128, 192, 0, 64, 128, 192, 0, 32, 64, 128, 0, 64, 128, 192};
    int tv_exp  [16] = '{2, 127, -2, -127, -128, -64, 0, 64, -128, -64, 0, 127,
                         127, 127, -127, -127};

    initial begin
        bit seen;
        reset = 1'b1; en = 1'b0; ftw_in = '0; ftw_valid = 1'b0; ftw_sync = 1'b0;
        phase_off = '0; phase_clr = 1'b0; mode = 2'd0;
        m_acc = '0; m_ftw = '0; m_carry = 1'b0;

        #2 reset = 1'b0;
        #2;
        check_eq("rst_wave", wave, 0);
        check_eq("rst_valid", wave_valid, 0);
        check_eq("rst_ready", ftw_ready, 1);
        check_eq("rst_msb", acc_msb, 0);
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;

        // 1: FTW=2^24 immediate load, sine sweep
        ftw_in = 32'h0100_0000; ftw_valid = 1'b1; ftw_sync = 1'b0; en = 1'b1;
        advance();
        m_ftw = 32'h0100_0000;
        ftw_valid = 1'b0;
        for (int j = 1; j <= 262; j++) begin
            if (j > 1) advance();
            check_eq("t1_msb", acc_msb, int'(m_acc[31:24]));
            if (j == 2) check_eq("t1_valid_lo", wave_valid, 0);
            if (j == 3) check_eq("t1_valid_hi", wave_valid, 1);
            // wave after edge j shows the phase held after edge j-3, i.e. msb j-4
            case (j - 4)
                0:   check_eq("t1_sin_p0", wave, 2);
                64:  check_eq("t1_sin_p64", wave, 127);
                128: check_eq("t1_sin_p128", wave, -2);
                192: check_eq("t1_sin_p192", wave, -127);
                default: ;
            endcase
        end

        // 2: wrap-synchronous load of 2^25
        ftw_in = 32'h0200_0000; ftw_sync = 1'b1; ftw_valid = 1'b1;
        advance();
        ftw_valid = 1'b0; ftw_sync = 1'b0;
        check_eq("t2_ready_pend", ftw_ready, 0);
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            if (k == 5) begin ftw_valid = 1'b1; ftw_in = '0; end
            advance();
            ftw_valid = 1'b0;
            check_eq("t2_msb", acc_msb, int'(m_acc[31:24]));
            if (m_carry) begin
                m_ftw = 32'h0200_0000;
                seen = 1'b1;
                check_eq("t2_ready_after_wrap", ftw_ready, 1);
            end else begin
                check_eq("t2_ready_held", ftw_ready, 0);
            end
        end
        repeat (3) begin
            advance();
            check_eq("t2_msb_step2", acc_msb, int'(m_acc[31:24]));
        end

        // 3: phase_clr while pending, and clr beating an accept in IDLE
        ftw_in = 32'h0040_0000; ftw_sync = 1'b1; ftw_valid = 1'b1;
        advance();
        check_eq("t3_ready_pend", ftw_ready, 0);
        ftw_in = 32'h0010_0000; ftw_sync = 1'b0; ftw_valid = 1'b1; phase_clr = 1'b1;
        advance();
        m_ftw = 32'h0040_0000;
        check_eq("t3_clr_msb", acc_msb, 0);
        check_eq("t3_clr_ready", ftw_ready, 1);
        advance();
        check_eq("t3_msb_a", acc_msb, int'(m_acc[31:24]));
        advance();
        ftw_valid = 1'b0; phase_clr = 1'b0;
        check_eq("t3_clr2_msb", acc_msb, 0);
        repeat (8) begin
            advance();
            check_eq("t3_msb", acc_msb, int'(m_acc[31:24]));
        end

        // 4: waveform modes at fixed phase (FTW=0, acc=0)
        ftw_in = '0; ftw_valid = 1'b1;
        advance();
        m_ftw = '0;
        ftw_valid = 1'b0; phase_clr = 1'b1;
        advance();
        phase_clr = 1'b0;
        check_eq("t4_msb0", acc_msb, 0);
        for (int t = 0; t < 16; t++) begin
            mode = 2'(tv_mode[t]);
            phase_off = 8'(tv_p[t]);
            repeat (3) advance();
            check_eq($sformatf("t4_m%0d_p%0d", tv_mode[t], tv_p[t]), wave, tv_exp[t]);
        end

        // 5: constant phase via offset, then asynchronous reset mid-run
        mode = 2'd0; phase_off = 8'd64;
        repeat (3) advance();
        repeat (4) begin
            advance();
            check_eq("t5_const", wave, 127);
        end
        ftw_in = 32'h0100_0000; ftw_valid = 1'b1;
        advance();
        m_ftw = 32'h0100_0000;
        ftw_valid = 1'b0;
        repeat (10) advance();
        check_eq("t5_msb_run", acc_msb, int'(m_acc[31:24]));
        ftw_in = 32'h0300_0000; ftw_sync = 1'b1; ftw_valid = 1'b1;
        advance();
        ftw_valid = 1'b0; ftw_sync = 1'b0;
        check_eq("t5_ready_pend", ftw_ready, 0);
        #3 reset = 1'b0;
        #1;
        check_eq("t5_rst_wave", wave, 0);
        check_eq("t5_rst_valid", wave_valid, 0);
        check_eq("t5_rst_ready", ftw_ready, 1);
        check_eq("t5_rst_msb", acc_msb, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        m_acc = '0; m_ftw = '0;
        ftw_in = 32'h0100_0000; ftw_valid = 1'b1;
        advance();
        m_ftw = 32'h0100_0000;
        ftw_valid = 1'b0;
        check_eq("t5_restart_msb0", acc_msb, 0);
        for (int i = 2; i <= 5; i++) begin
            advance();
            check_eq("t5_restart_msb", acc_msb, int'(m_acc[31:24]));
            if (i == 2) check_eq("t5_valid_lo", wave_valid, 0);
            if (i == 3) check_eq("t5_valid_hi", wave_valid, 1);
        end
        en = 1'b0;
        for (int i = 6; i <= 8; i++) begin
            advance();
            check_eq("t5_hold_msb", acc_msb, int'(m_acc[31:24]));
            if (i == 7) check_eq("t5_valid_tail", wave_valid, 1);
            if (i == 8) check_eq("t5_valid_drop", wave_valid, 0);
        end

        // 6: FTW=2^23, msb advances by one every two enabled cycles
        en = 1'b1;
        ftw_in = 32'h0080_0000; ftw_valid = 1'b1;
        advance();
        m_ftw = 32'h0080_0000;
        ftw_valid = 1'b0;
        repeat (64) begin
            advance();
            check_eq("t6_msb", acc_msb, int'(m_acc[31:24]));
        end
        check_eq("t6_ready", ftw_ready, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
